hazard_issue_seq: RTL and testbench
===================================

// Module: hazard_issue_seq
// PURPOSE
//  Sequential issue stage that sits between the 8-instruction program window and the ID stage
//  of the 8-bit 5-stage core.
//  Accepts one packed program (N_INSTR x 8-bit) through a valid/ready handshake, then issues one
//  slot per cycle to ID.
//  Inserts noop bubbles (8'h00) when an instruction reads a register written by one of the last
//  HAZ_WIN issued slots. There is no forwarding; the register file writes before it reads.
// PARAMETERS
//  N_INSTR  8  instructions per program; prog_bits width = 8*N_INSTR; instr 0 at MSB byte
//  HAZ_WIN  2  issued slots still in flight before WB (legal 1..3)
// PORTS
//  clk           in   1        clock; all state updates on rising edge
//  rst_n         in   1        async active-low reset
//  prog_valid    in   1        prog_bits valid
//  prog_ready    out  1        block idle and able to accept a program
//  prog_bits     in   8*N      packed program; instr i = prog_bits[8*(N-i)-1 -: 8]
//  issue_ready   in   1        ID can take a slot; 0 = pipeline frozen
//  issue_valid   out  1        issue_instr holds a slot for ID
//  issue_instr   out  8        issued instruction or bubble (8'h00)
//  issue_bubble  out  1        current slot is an inserted bubble
//  done          out  1        one-cycle pulse after last program instr is accepted by ID
//  stall_count   out  8        bubbles inserted for current/last program, saturates at 255
// BEHAVIOUR
//  Decode: opc=[7:6]; A=[5:3]; B=[2:0]; 00 noop, 01 add, 10 sw, 11 lw
//   add: reads A and B, writes A | lw: reads B (base), writes A | sw: reads A and B, writes none
//   noop: reads none, writes none. r0 (3'b000) never causes a hazard as source or dest.
//  Scoreboard: HAZ_WIN entries {valid,dest}; shifts only when a slot is accepted
//   (issue_valid & issue_ready). Shift-in value is the issued instr's dest, or invalid for a
//   bubble/sw/noop.
//  Hazard: a read reg of instr[pc] matches any valid scoreboard dest.
//  FSM IDLE -> ISSUE -> DONE -> IDLE
//   IDLE : prog_ready=1, issue_valid=0. On prog_valid: latch program, pc=0, clear scoreboard,
//          clear stall_count, go to ISSUE.
//   ISSUE: issue_valid=1. Outputs are registered; first slot is visible the cycle after the
//          accept. On accept:
//          - if the next candidate has a hazard, load a bubble and stall_count++ (saturating).
//          - otherwise load instr[pc] and pc++.
//          When the slot holding instr N-1 is accepted, go to DONE.
//   DONE : done=1 for one cycle, issue_valid=0, then go to IDLE.
//  issue_ready=0: issue_instr, issue_bubble, pc, scoreboard and stall_count all hold.
//   Hazard evaluation is not re-run.
//  prog_valid while not IDLE: ignored; prog_ready=0.
//  Back-to-back programs: the scoreboard is cleared at accept. The first instr of a new program
//   never stalls on the prior one.
//  Reset (any time, incl. mid-program): state=IDLE, prog_ready=1, issue_valid=0,
//   issue_instr=8'h00, issue_bubble=0, done=0, stall_count=0, pc=0, scoreboard all invalid.
//  Throughput: hazard-free program issues N_INSTR slots in N_INSTR consecutive cycles.
// TESTING
//  1. add r1,r2 (8'h4A); add r3,r1 (8'h59); 6 noops -> 4A,00(b),00(b),59,...;
//     stall_count=2; done once.
//  2. 8 independent adds (4A,5C,...) with issue_ready=1 -> 8 slots in 8 cycles, no bubble,
//     stall_count=0.
//  3. add r1,r2; noop; add r3,r1 -> exactly 1 bubble before 8'h59; stall_count=1.
//  4. lw r1,(r2) (8'hCA); sw r1,(r3) (8'h8B); add r4,r1 (8'h61) -> 2 bubbles before 8B,
//     none before 61 (r1 dest retired); stall_count=2.
//  5. add r0,r1 (8'h41); add r2,r0 (8'h50) -> no bubble; then issue_ready=0 for 3 cycles
//     mid-program -> outputs/pc frozen, resume unchanged.
//  6. Assert rst_n=0 during ISSUE at pc=4 -> immediate IDLE, all outputs at reset values;
//     new program accepted normally.

Source files
------------

// File: rtl/hazard_issue_seq_if.sv
// Handshake bundle between the program window, the hazard issue stage and ID.
// The master side supplies programs and the ID ready; the slave side is the issue stage.
interface hazard_issue_seq_if #(
  parameter int N_INSTR = 8
);
  logic                   prog_valid;
  logic                   prog_ready;
  logic [8*N_INSTR-1:0]   prog_bits;
  logic                   issue_ready;
  logic                   issue_valid;
  logic [7:0]             issue_instr;
  logic                   issue_bubble;
  logic                   done;
  logic [7:0]             stall_count;

  modport master (
    output prog_valid, prog_bits, issue_ready,
    input  prog_ready, issue_valid, issue_instr, issue_bubble, done, stall_count
  );

  modport slave (
    input  prog_valid, prog_bits, issue_ready,
    output prog_ready, issue_valid, issue_instr, issue_bubble, done, stall_count
  );
endinterface

// File: rtl/hazard_issue_seq.sv
// Issue stage for the 8-bit 5-stage core: takes one packed program, issues one slot per
// cycle to ID and inserts noop bubbles while a source register is still in flight.
module hazard_issue_seq #(
  parameter int N_INSTR = 8,
  parameter int HAZ_WIN = 2
) (
  input logic               clk,
  input logic               rst_n,
  hazard_issue_seq_if.slave bus
);
  localparam int PcW  = $clog2(N_INSTR + 1);
  localparam int IdxW = (N_INSTR > 1) ? $clog2(N_INSTR) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} stateT;

  stateT                    state, nextState;
  logic [7:0]               progArr [N_INSTR];
  logic [PcW-1:0]           pc;
  logic [HAZ_WIN-1:0]       sbValid, shValid;
  logic [HAZ_WIN-1:0][2:0]  sbDest, shDest;
  logic [7:0]               issueInstr, stallCount, candidate;
  logic [3:0]               newest;
  logic                     issueBubble, hazard, accept, progAccept, lastSlot;
  logic                     readA, readB;

  // Destination of an instruction as {valid, reg}; r0 never counts as a destination.
  function automatic logic [3:0] destOf(input logic [7:0] ins);
    destOf = 4'h0;
    if ((ins[7:6] == 2'b01 || ins[7:6] == 2'b11) && ins[5:3] != 3'b000)
      destOf = {1'b1, ins[5:3]};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and handshake outputs
  always_comb begin
    nextState       = state;
    progAccept      = 1'b0;
    accept          = 1'b0;
    bus.prog_ready  = 1'b0;
    bus.issue_valid = 1'b0;
    bus.done        = 1'b0;
    case (state)
      IDLE: begin
        bus.prog_ready = 1'b1;
        if (bus.prog_valid) begin
          progAccept = 1'b1;
          nextState  = ISSUE;
        end
      end
      ISSUE: begin
        bus.issue_valid = 1'b1;
        if (bus.issue_ready) begin
          accept = 1'b1;
          if (lastSlot) nextState = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // pc names the next candidate, so the slot holding the final instruction is up once pc == N_INSTR.
  assign lastSlot = (pc == PcW'(N_INSTR));

  // Hazard test runs against the scoreboard as it will look after the current slot retires into it.
  always_comb begin
    newest     = issueBubble ? 4'h0 : destOf(issueInstr);
    shValid[0] = newest[3];
    shDest[0]  = newest[2:0];
    for (int k = 1; k < HAZ_WIN; k++) begin
      shValid[k] = sbValid[k-1];
      shDest[k]  = sbDest[k-1];
    end
    candidate = (pc < PcW'(N_INSTR)) ? progArr[pc[IdxW-1:0]] : 8'h00;
    readA     = (candidate[7:6] == 2'b01) || (candidate[7:6] == 2'b10);
    readB     = (candidate[7:6] != 2'b00);
    hazard    = 1'b0;
    for (int k = 0; k < HAZ_WIN; k++) begin
      if (shValid[k] && ((readA && candidate[5:3] == shDest[k]) ||
                         (readB && candidate[2:0] == shDest[k])))
        hazard = 1'b1;
    end
  end

  // Program store, issue slot, scoreboard and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INSTR; i++) progArr[i] <= 8'h00;
      issueInstr  <= 8'h00;
      issueBubble <= 1'b0;
      pc          <= '0;
      sbValid     <= '0;
      sbDest      <= '0;
      stallCount  <= 8'h00;
    end else if (progAccept) begin
      for (int i = 0; i < N_INSTR; i++) progArr[i] <= bus.prog_bits[8*(N_INSTR-i)-1 -: 8];
      issueInstr  <= bus.prog_bits[8*N_INSTR-1 -: 8];
      issueBubble <= 1'b0;
      pc          <= PcW'(1);
      sbValid     <= '0;
      sbDest      <= '0;
      stallCount  <= 8'h00;
    end else if (accept) begin
      sbValid <= shValid;
      sbDest  <= shDest;
      if (!lastSlot) begin
        if (hazard) begin
          issueInstr  <= 8'h00;
          issueBubble <= 1'b1;
          if (stallCount != 8'hFF) stallCount <= stallCount + 8'd1;
        end else begin
          issueInstr  <= candidate;
          issueBubble <= 1'b0;
          pc          <= pc + PcW'(1);
        end
      end
    end
  end

  assign bus.issue_instr  = issueInstr;
  assign bus.issue_bubble = issueBubble;
  assign bus.stall_count  = stallCount;
endmodule

// File: tb/tb_hazard_issue_seq.sv
// Self-checking bench for hazard_issue_seq: directed programs plus random programs with random
// ID back-pressure, compared against a slot-sequence model of the issue rules.
module tb_hazard_issue_seq;
  localparam int N_INSTR = 8;
  localparam int HAZ_WIN = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] expInstr[$];
  bit         expBub[$];
  int         expStalls;

  hazard_issue_seq_if #(.N_INSTR(N_INSTR)) bus ();

  hazard_issue_seq #(.N_INSTR(N_INSTR), .HAZ_WIN(HAZ_WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hist holds the destination of each of the last HAZ_WIN issued slots, 0 meaning none.
  function automatic bit hazardous(input logic [7:0] ins, input int hist[$]);
    int a, b;
    bit rA, rB;
    a  = int'(ins[5:3]);
    b  = int'(ins[2:0]);
    rA = (ins[7:6] == 2'b01) || (ins[7:6] == 2'b10);
    rB = (ins[7:6] != 2'b00);
    foreach (hist[j])
      if (hist[j] > 0 && ((rA && hist[j] == a) || (rB && hist[j] == b))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int destReg(input logic [7:0] ins);
    if (ins[7:6] == 2'b01 || ins[7:6] == 2'b11) return int'(ins[5:3]);
    return 0;
  endfunction

  task automatic buildExpected(input logic [8*N_INSTR-1:0] prog);
    int hist[$];
    logic [7:0] ins;
    expInstr.delete();
    expBub.delete();
    expStalls = 0;
    for (int i = 0; i < N_INSTR; i++) begin
      ins = prog[8*(N_INSTR-i)-1 -: 8];
      while (hazardous(ins, hist)) begin
        expInstr.push_back(8'h00);
        expBub.push_back(1'b1);
        expStalls++;
        hist.push_back(0);
        if (hist.size() > HAZ_WIN) void'(hist.pop_front());
      end
      expInstr.push_back(ins);
      expBub.push_back(1'b0);
      hist.push_back(destReg(ins));
      if (hist.size() > HAZ_WIN) void'(hist.pop_front());
    end
  endtask

  // mode 0: ID always ready; 1: random ready; 2: ID frozen for three cycles early on
  task automatic applyStimulus(input logic [8*N_INSTR-1:0] prog, input int mode,
                               input int specStall, input string name);
    int idx, cyc;
    bit rdy, seenDone, abort, lastValid, lastRdy, lastBub;
    logic [7:0] lastInstr, lastStall;
    buildExpected(prog);
    @(negedge clk);
    checks++;
    if (bus.prog_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s prog_ready before accept: got %b expected 1", name, bus.prog_ready);
    end
    bus.prog_bits  = prog;
    bus.prog_valid = 1'b1;
    @(negedge clk);
    bus.prog_valid = 1'b0;
    bus.prog_bits  = {$urandom, $urandom};
    idx = 0; cyc = 0; seenDone = 0; abort = 0; lastValid = 0; lastRdy = 1;
    lastInstr = 8'h00; lastBub = 0; lastStall = 8'h00;
    while (!seenDone && !abort && cyc < 300) begin
      if (bus.done === 1'b1) begin
        seenDone = 1;
      end else if (bus.issue_valid === 1'b1) begin
        if (lastValid && !lastRdy) begin
          checks++;
          if ({bus.issue_instr, bus.issue_bubble, bus.stall_count} !== {lastInstr, lastBub, lastStall}) begin
            errors++;
            $display("[TB] FAIL %s frozen hold cyc%0d: got %h/%b/%0d expected %h/%b/%0d", name, cyc,
                     bus.issue_instr, bus.issue_bubble, bus.stall_count, lastInstr, lastBub, lastStall);
          end
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 3) != 0);
          default: rdy = !(cyc >= 2 && cyc <= 4);
        endcase
        bus.issue_ready = rdy;
        if (rdy) begin
          checks++;
          if (idx >= expInstr.size()) begin
            errors++;
            $display("[TB] FAIL %s extra slot %0d: got %h expected none", name, idx, bus.issue_instr);
          end else if (bus.issue_instr !== expInstr[idx] || bus.issue_bubble !== expBub[idx]) begin
            errors++;
            $display("[TB] FAIL %s slot%0d: got %h bubble %b expected %h bubble %b", name, idx,
                     bus.issue_instr, bus.issue_bubble, expInstr[idx], expBub[idx]);
          end
          idx++;
        end
        lastValid = 1; lastRdy = rdy;
        lastInstr = bus.issue_instr; lastBub = bus.issue_bubble; lastStall = bus.stall_count;
      end else begin
        checks++;
        errors++;
        abort = 1;
        $display("[TB] FAIL %s cyc%0d neither issue_valid nor done: got valid %b done %b", name, cyc,
                 bus.issue_valid, bus.done);
      end
      if (!seenDone && !abort) begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!seenDone) begin
      errors++;
      $display("[TB] FAIL %s done pulse: got none after %0d cycles expected one", name, cyc);
    end
    checks++;
    if (idx != expInstr.size()) begin
      errors++;
      $display("[TB] FAIL %s slot count: got %0d expected %0d", name, idx, expInstr.size());
    end
    checks++;
    if (bus.stall_count !== 8'(expStalls)) begin
      errors++;
      $display("[TB] FAIL %s stall_count: got %0d expected %0d", name, bus.stall_count, expStalls);
    end
    if (specStall >= 0) begin
      checks++;
      if (bus.stall_count !== 8'(specStall)) begin
        errors++;
        $display("[TB] FAIL %s stall_count literal: got %0d expected %0d", name, bus.stall_count, specStall);
      end
    end
    if (mode == 0) begin
      checks++;
      if (cyc != expInstr.size()) begin
        errors++;
        $display("[TB] FAIL %s throughput: got %0d cycles expected %0d", name, cyc, expInstr.size());
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.prog_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s after done: got done %b prog_ready %b expected 0 1", name, bus.done, bus.prog_ready);
    end
  endtask

  task automatic checkOutput(input string name);
    checks++;
    if ({bus.prog_ready, bus.issue_valid, bus.issue_instr, bus.issue_bubble, bus.done, bus.stall_count}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL %s reset outputs: got rdy %b vld %b instr %h bub %b done %b stalls %0d expected 1 0 00 0 0 0",
               name, bus.prog_ready, bus.issue_valid, bus.issue_instr, bus.issue_bubble, bus.done, bus.stall_count);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3 checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hazard_basic();
    applyStimulus(64'h4A59_0000_0000_0000, 0, 2, "raw_two_bubbles");
  endtask

  task automatic test_throughput();
    applyStimulus(64'h4A5C_6E7F_4858_6878, 0, 0, "independent_adds");
  endtask

  task automatic test_gap();
    applyStimulus(64'h4A00_5900_0000_0000, 0, 1, "one_gap");
  endtask

  task automatic test_load_store();
    applyStimulus(64'hCA8B_6100_0000_0000, 0, 2, "lw_sw_add");
  endtask

  task automatic test_freeze();
    applyStimulus(64'h4150_0000_0000_0000, 2, 0, "r0_and_freeze");
  endtask

  task automatic test_reset_mid();
    buildExpected(64'h4A5C_6E7F_4858_6878);
    @(negedge clk);
    bus.issue_ready = 1'b1;
    bus.prog_bits   = 64'h4A5C_6E7F_4858_6878;
    bus.prog_valid  = 1'b1;
    @(negedge clk);
    bus.prog_valid  = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.issue_instr !== expInstr[4]) begin
      errors++;
      $display("[TB] FAIL reset_mid slot4 before reset: got %h expected %h", bus.issue_instr, expInstr[4]);
    end
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(64'h4A59_0000_0000_0000, 0, 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    applyStimulus(64'h0000_0000_0000_004A, 0, 0, "b2b_first");
    applyStimulus(64'h5900_0000_0000_0000, 0, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) applyStimulus({$urandom, $urandom}, 1, -1, $sformatf("random%0d", n));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b1;
    bus.prog_valid  = 1'b0;
    bus.prog_bits   = '0;
    bus.issue_ready = 1'b0;
    test_reset();
    test_hazard_basic();
    test_throughput();
    test_gap();
    test_load_store();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
